// File: rtl/cim_mem_arbiter.sv
// cim_mem_arbiter
// Round-robin arbiter for the single-port CiM temporary-result SRAM.
// One request is accepted per cycle; the accepted command is registered onto
// the SRAM pins the following cycle. Reads are tagged with the one-hot source
// and the tag travels alongside the SRAM read latency so the returning data
// can be steered back to its owner.
//
// Handshake: a source holds read_req_src/write_req_src (with a stable address
// and write data) until grant[src] is seen high; grant is combinational in the
// same cycle and is the only acknowledgement. When a source raises read and
// write together, the write is accepted first and the source drops its write
// request in the following cycle, which leaves the read to be accepted next.
module cim_mem_arbiter #(
  parameter int NUM_SRC    = 7,
  parameter int DEPTH      = 48,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int DATA_W     = 16,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        read_req_src,
  input  logic [NUM_SRC-1:0]        write_req_src,
  input  logic [NUM_SRC*ADDR_W-1:0] addr_table,
  input  logic [NUM_SRC*DATA_W-1:0] write_data,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      grant_is_wr,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_SRC-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      oob_err
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  // One extra bit so the range check also works when DEPTH is a power of two.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  // Round-robin pointer: index of the highest-priority source this cycle.
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Registered SRAM command.
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  // Sticky out-of-range flag.
  logic               oob_q, oob_d;

  // Read-tag pipeline. Stage 0 lines up with the SRAM command cycle, stage
  // MEM_RD_LAT with the cycle mem_rdata is valid. drop marks reads that were
  // never sent to the SRAM so their returned data is forced to zero.
  logic [NUM_SRC-1:0] tag_q [MEM_RD_LAT+1];
  logic [NUM_SRC-1:0] tag_d [MEM_RD_LAT+1];
  logic [MEM_RD_LAT:0] drop_q, drop_d;

  // Arbitration results.
  logic [NUM_SRC-1:0] cand;
  logic               found;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_SRC-1:0] gnt_vec;
  logic               sel_wr;
  logic               sel_rd;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               addr_ok;
  int                 scan;

  // Pick the first requesting source at or after rr_ptr, wrapping around.
  always_comb begin
    cand      = read_req_src | write_req_src;
    found     = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= NUM_SRC) scan = scan - NUM_SRC;
      if (!found && cand[PTR_W'(scan)]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(scan);
      end
    end
    // Nothing is accepted while reset is applied.
    if (!rst_n) found = 1'b0;
    gnt_vec = '0;
    if (found) gnt_vec[gnt_idx] = 1'b1;
    sel_wr    = found & write_req_src[gnt_idx];
    sel_rd    = found & read_req_src[gnt_idx];
    sel_addr  = addr_table[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_wdata = write_data[int'(gnt_idx)*DATA_W +: DATA_W];
    addr_ok   = ({1'b0, sel_addr} < DEPTH_X);
  end

  // Next-state for pointer, SRAM command, error flag and read tags.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    oob_d       = oob_q;

    if (found) begin
      // A write accepted while the same source also reads keeps the pointer,
      // so that source's read is found first on the next cycle.
      if (!(sel_wr && sel_rd)) begin
        rr_ptr_d = (gnt_idx == PTR_W'(NUM_SRC-1)) ? '0 : gnt_idx + PTR_W'(1);
      end
      if (addr_ok) begin
        mem_en_d    = 1'b1;
        mem_we_d    = sel_wr;
        mem_addr_d  = sel_addr;
        mem_wdata_d = sel_wdata;
      end else begin
        oob_d = 1'b1;
      end
    end

    tag_d[0]  = (found && !sel_wr) ? gnt_vec : '0;
    drop_d[0] = found & ~sel_wr & ~addr_ok;
    for (int s = 1; s <= MEM_RD_LAT; s++) begin
      tag_d[s]  = tag_q[s-1];
      drop_d[s] = drop_q[s-1];
    end
  end

  // State registers; reset discards any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      oob_q       <= 1'b0;
      drop_q      <= '0;
      for (int s = 0; s <= MEM_RD_LAT; s++) tag_q[s] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      oob_q       <= oob_d;
      drop_q      <= drop_d;
      for (int s = 0; s <= MEM_RD_LAT; s++) tag_q[s] <= tag_d[s];
    end
  end

  assign grant       = gnt_vec;
  assign grant_is_wr = sel_wr;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign oob_err     = oob_q;
  assign rd_valid    = tag_q[MEM_RD_LAT];
  assign rd_data     = drop_q[MEM_RD_LAT] ? '0 : mem_rdata;

  // Grant and read return are each at most one-hot.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_rdv_onehot0   : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rd_valid));

endmodule
